servo_pwm_multi: RTL and testbench

Parametrised multi-channel servo pulse generator for the Segway fabric: generalises the single GPIO-driven continuous-servo output into NUM_CH independent hardware PWM channels sharing one frame timebase. Software or a control block writes per-channel pulse widths in microseconds. Widths are clamped, then applied at frame boundaries with optional per-frame slew limiting, giving glitch-free outputs. Sits between the MSS/controller write path and the servo/ESC pins.

---
 rtl/servo_pkg.sv | 41 ++++
 rtl/servo_timebase.sv | 48 ++++
 rtl/servo_pwm_multi.sv | 94 +++++++++
 tb/tb_servo_pwm_multi.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// servo_pkg: shared constants and width helpers for servo_pwm_multi.
// Holds default parameters, clamp and per-frame slew-step functions.
package servo_pkg;

    localparam int DEF_NUM_CH     = 4;
    localparam int DEF_CLK_PER_US = 10;
    localparam int DEF_FRAME_US   = 20000;
    localparam int DEF_MIN_US     = 1000;
    localparam int DEF_MAX_US     = 2000;
    localparam int DEF_NEUTRAL_US = 1500;
    localparam int DEF_SLEW_US    = 50;

    // Counter width that stays legal when the modulus is 1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [15:0] clamp_us(
        input logic [15:0] d,
        input logic [15:0] lo,
        input logic [15:0] hi
    );
        if (d < lo) return lo;
        if (d > hi) return hi;
        return d;
    endfunction

    // One frame of movement from act toward tgt; slew of 0 jumps directly.
    function automatic logic [15:0] slew_step(
        input logic [15:0] act,
        input logic [15:0] tgt,
        input logic [15:0] slew
    );
        logic [15:0] diff;
        diff = (tgt >= act) ? (tgt - act) : (act - tgt);
        if (slew == 16'd0 || diff <= slew) return tgt;
        if (tgt > act) return act + slew;
        return act - slew;
    endfunction

endpackage

// File: rtl/servo_timebase.sv
// servo_timebase: microsecond prescaler and frame counter.
// Produces the frame boundary strike, next-count lookahead and frame_start.
module servo_timebase
    import servo_pkg::*;
#(
    parameter int CLK_PER_US = DEF_CLK_PER_US,
    parameter int FRAME_US   = DEF_FRAME_US,
    parameter int CW         = cnt_w(FRAME_US)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    output logic          o_boundary,
    output logic [CW-1:0] o_cnt_next,
    output logic          o_frame_start
);

    localparam int PW = cnt_w(CLK_PER_US);

    logic [PW-1:0] r_presc;
    logic [CW-1:0] r_us_cnt;
    logic          r_frame_start;
    logic          w_us_tick;
    logic          w_boundary;
    logic [CW-1:0] w_cnt_next;

    assign w_us_tick  = (r_presc == PW'(CLK_PER_US - 1));
    assign w_boundary = w_us_tick && (r_us_cnt == CW'(FRAME_US - 1));
    assign w_cnt_next = !w_us_tick ? r_us_cnt :
                        (w_boundary ? '0 : r_us_cnt + CW'(1));

    // Advance prescaler and us counter; flag the cycle that opens a frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_presc       <= '0;
            r_us_cnt      <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_presc       <= w_us_tick ? '0 : r_presc + PW'(1);
            r_us_cnt      <= w_cnt_next;
            r_frame_start <= w_boundary;
        end
    end

    assign o_boundary    = w_boundary;
    assign o_cnt_next    = w_cnt_next;
    assign o_frame_start = r_frame_start;

endmodule

// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: NUM_CH servo PWM channels on one shared frame timebase.
// Targets are clamped on write and applied, slew-limited, at frame boundaries.
module servo_pwm_multi
    import servo_pkg::*;
#(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int CLK_PER_US = DEF_CLK_PER_US,
    parameter int FRAME_US   = DEF_FRAME_US,
    parameter int MIN_US     = DEF_MIN_US,
    parameter int MAX_US     = DEF_MAX_US,
    parameter int NEUTRAL_US = DEF_NEUTRAL_US,
    parameter int SLEW_US    = DEF_SLEW_US
) (
    input  logic              SYSCLK,
    input  logic              NSYSRESET,
    input  logic              wr_valid,
    input  logic [7:0]        wr_ch,
    input  logic [15:0]       wr_data,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              frame_start,
    output logic [NUM_CH-1:0] settled,
    output logic              wr_err
);

    localparam int CW = cnt_w(FRAME_US);

    logic          w_boundary;
    logic [CW-1:0] w_cnt_next;
    logic          w_bad_wr;
    logic          r_wr_err;

    servo_timebase #(
        .CLK_PER_US (CLK_PER_US),
        .FRAME_US   (FRAME_US),
        .CW         (CW)
    ) u_tb (
        .i_clk         (SYSCLK),
        .i_rst_n       (NSYSRESET),
        .o_boundary    (w_boundary),
        .o_cnt_next    (w_cnt_next),
        .o_frame_start (frame_start)
    );

    assign w_bad_wr = wr_valid && ({24'd0, wr_ch} >= 32'(NUM_CH));

    // Out-of-range channel writes are dropped and reported one cycle later.
    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) r_wr_err <= 1'b0;
        else            r_wr_err <= w_bad_wr;
    end

    assign wr_err = r_wr_err;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [15:0] r_target;
        logic [15:0] r_active;
        logic        r_en;
        logic        r_pwm;
        logic        r_settled;
        logic        w_hit;
        logic        w_en_next;
        logic [15:0] w_act_next;

        assign w_hit      = wr_valid && (wr_ch == 8'(i));
        assign w_en_next  = w_boundary ? ch_en[i] : r_en;
        assign w_act_next = w_boundary ?
                            slew_step(r_active, r_target, 16'(SLEW_US)) :
                            r_active;

        // Width and enable only move at the boundary, so pulses never runt.
        always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
            if (!NSYSRESET) begin
                r_target  <= 16'(NEUTRAL_US);
                r_active  <= 16'(NEUTRAL_US);
                r_en      <= 1'b0;
                r_pwm     <= 1'b0;
                r_settled <= 1'b1;
            end else begin
                if (w_hit)
                    r_target <= clamp_us(wr_data, 16'(MIN_US), 16'(MAX_US));
                r_active  <= w_act_next;
                r_en      <= w_en_next;
                r_pwm     <= w_en_next &&
                             (32'(w_cnt_next) < 32'(w_act_next));
                r_settled <= (r_active == r_target);
            end
        end

        assign pwm_out[i] = r_pwm;
        assign settled[i] = r_settled;
    end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// tb_servo_pwm_multi: directed bench with a frame-level reference model.
// Small frame parameters keep each frame at 2000 clock cycles.
`timescale 1ns/1ps
module tb_servo_pwm_multi;

    localparam int NCH  = 4;
    localparam int CPU  = 10;
    localparam int FUS  = 200;
    localparam int MINU = 50;
    localparam int MAXU = 150;
    localparam int NEU  = 100;
    localparam int SLW  = 10;
    localparam int FCYC = FUS * CPU;

    logic           clk      = 1'b0;
    logic           rst_n    = 1'b1;
    logic           wr_valid = 1'b0;
    logic [7:0]     wr_ch    = 8'd0;
    logic [15:0]    wr_data  = 16'd0;
    logic [NCH-1:0] ch_en    = 4'hF;
    logic [NCH-1:0] pwm_out;
    logic           frame_start;
    logic [NCH-1:0] settled;
    logic           wr_err;

    always #5 clk = ~clk;

    servo_pwm_multi #(
        .NUM_CH     (NCH),
        .CLK_PER_US (CPU),
        .FRAME_US   (FUS),
        .MIN_US     (MINU),
        .MAX_US     (MAXU),
        .NEUTRAL_US (NEU),
        .SLEW_US    (SLW)
    ) dut (
        .SYSCLK      (clk),
        .NSYSRESET   (rst_n),
        .wr_valid    (wr_valid),
        .wr_ch       (wr_ch),
        .wr_data     (wr_data),
        .ch_en       (ch_en),
        .pwm_out     (pwm_out),
        .frame_start (frame_start),
        .settled     (settled),
        .wr_err      (wr_err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Reference model: cycle index within the run and per-channel widths in us.
    int m_t;
    int m_tgt [NCH];
    int m_act [NCH];
    bit m_en  [NCH];
    bit m_ps  [NCH];
    bit m_perr;

    function automatic int mclamp(input int d);
        if (d < MINU) return MINU;
        if (d > MAXU) return MAXU;
        return d;
    endfunction

    function automatic int mstep(input int a, input int t);
        if (t > a) return (t - a <= SLW) ? t : a + SLW;
        return (a - t <= SLW) ? t : a - SLW;
    endfunction

    // Compare every cycle, then advance the model with this cycle's inputs.
    always @(negedge clk) begin
        logic [NCH-1:0] e_pwm;
        logic [NCH-1:0] e_set;
        logic           e_fs;
        logic           e_err;
        logic [9:0]     ev;
        logic [9:0]     av;
        if (!rst_n) begin
            m_t = 0;
            for (int i = 0; i < NCH; i++) begin
                m_tgt[i] = NEU;
                m_act[i] = NEU;
                m_en[i]  = 1'b0;
                m_ps[i]  = 1'b1;
            end
            m_perr = 1'b0;
            e_pwm  = '0;
            e_set  = '1;
            e_fs   = 1'b0;
            e_err  = 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                e_pwm[i] = m_en[i] && ((m_t % FCYC) < m_act[i] * CPU);
                e_set[i] = m_ps[i];
            end
            e_fs  = (m_t != 0) && (m_t % FCYC == 0);
            e_err = m_perr;
        end
        ev = {e_pwm, e_fs, e_set, e_err};
        av = {pwm_out, frame_start, settled, wr_err};
        n_chk++;
        if (av === ev) n_pass++;
        else $display("FAIL cycle t=%0d pwm/fs/settled/err got %b expected %b",
                      m_t, av, ev);
        if (rst_n) begin
            for (int i = 0; i < NCH; i++) m_ps[i] = (m_act[i] == m_tgt[i]);
            m_perr = wr_valid && (int'(wr_ch) >= NCH);
            if (m_t % FCYC == FCYC - 1) begin
                for (int i = 0; i < NCH; i++) begin
                    m_en[i]  = ch_en[i];
                    m_act[i] = mstep(m_act[i], m_tgt[i]);
                end
            end
            if (wr_valid && int'(wr_ch) < NCH)
                m_tgt[wr_ch] = mclamp(int'(wr_data));
            m_t++;
        end
    end

    // Pulse-width recorder for the literal width checks.
    int cnt   [NCH];
    int lastw [NCH];
    int wq0[$];
    int wq1[$];
    int wq3[$];

    always @(negedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (!rst_n) begin
                cnt[i] = 0;
            end else if (pwm_out[i]) begin
                cnt[i]++;
            end else if (cnt[i] > 0) begin
                lastw[i] = cnt[i];
                if (i == 0) wq0.push_back(cnt[i]);
                if (i == 1) wq1.push_back(cnt[i]);
                if (i == 3) wq3.push_back(cnt[i]);
                cnt[i] = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int n);
        while (m_t < n) step();
    endtask

    task automatic wr(input int ch, input int d);
        wr_valid = 1'b1;
        wr_ch    = 8'(ch);
        wr_data  = 16'(d);
        step();
        wr_valid = 1'b0;
    endtask

    function automatic int qat(input int which, input int k);
        if (which == 0) return (wq0.size() > k) ? wq0[k] : -1;
        if (which == 1) return (wq1.size() > k) ? wq1[k] : -1;
        return (wq3.size() > k) ? wq3[k] : -1;
    endfunction

    initial begin
        bit found;
        for (int i = 0; i < NCH; i++) begin
            cnt[i]   = 0;
            lastw[i] = 0;
        end
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_frame_start", int'(frame_start), 0);
        chk("rst_settled", int'(settled), 15);
        chk("rst_wr_err", int'(wr_err), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        goto(2500);
        wr(1, 130);
        goto(2600);
        @(negedge clk);
        chk("settled1_after_wr", int'(settled[1]), 0);

        goto(4100);
        wr(0, 500);
        goto(4200);
        wr(4, 60);
        @(negedge clk);
        chk("wr_err_ch4_pulse", int'(wr_err), 1);
        step();
        @(negedge clk);
        chk("wr_err_ch4_clear", int'(wr_err), 0);

        goto(4300);
        wr(2, 60);
        wr(2, 140);
        goto(4400);
        wr(255, 120);
        @(negedge clk);
        chk("wr_err_ch255_pulse", int'(wr_err), 1);

        goto(FCYC * 3 - 1);
        wr(3, 50);

        goto(8000);
        @(negedge clk);
        chk("settled1_before_3rd", int'(settled[1]), 0);
        step();
        @(negedge clk);
        chk("settled1_after_3rd", int'(settled[1]), 1);

        goto(8300);
        ch_en = 4'b0111;
        goto(14100);
        wr(0, 0);
        goto(20000);
        ch_en = 4'hF;

        goto(36200);
        chk("ch0_w_f1", qat(0, 0), 1000);
        chk("ch1_w_f2", qat(1, 1), 1100);
        chk("ch1_w_f3", qat(1, 2), 1200);
        chk("ch1_w_f4", qat(1, 3), 1300);
        chk("ch1_w_f5", qat(1, 4), 1300);
        chk("ch0_w_clamp_hi", qat(0, 6), 1500);
        chk("ch0_w_clamp_lo", qat(0, 16), 500);
        chk("ch3_w_bnd_write", qat(3, 2), 1000);
        chk("ch3_w_en_drop", qat(3, 3), 900);
        chk("ch3_w_reenable", qat(3, 4), 500);

        chk("pre_rst_pwm", int'(pwm_out), 15);
        rst_n = 1'b0;
        #1;
        chk("mid_pulse_rst_pwm", int'(pwm_out), 0);
        repeat (5) step();
        rst_n = 1'b1;

        found = 1'b0;
        for (int k = 0; k < FCYC + 100 && !found; k++) begin
            @(negedge clk);
            if (frame_start) begin
                found = 1'b1;
                chk("first_fs_after_rst", k, FCYC);
            end
        end
        if (!found) chk("first_fs_after_rst_timeout", 0, 1);

        goto(3500);
        for (int i = 0; i < NCH; i++)
            chk($sformatf("post_rst_w_ch%0d", i), lastw[i], 1000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
